// File: rtl/ps2_tx.sv
// ps2_tx -- PS/2 host-to-device byte transmitter.
//
// Sends one command byte to a PS/2 device using the host request-to-send
// sequence. The host inhibits the clock, drives the start bit, and then
// follows the device-generated clock. It then checks the device acknowledge.
//
// Ports:
//   clk28       system clock (the only clock)
//   rst_n       asynchronous reset, active low
//   ps2_clk_in  raw PS/2 clock line level (asynchronous)
//   ps2_dat_in  raw PS/2 data line level (asynchronous)
//   ps2_clk_oe  1 = pull PS/2 clock low, 0 = release (open drain)
//   ps2_dat_oe  1 = pull PS/2 data low, 0 = release (open drain)
//   tx_data     byte to send
//   tx_valid    request to send tx_data
//   tx_ready    block can accept a byte (IDLE only)
//   busy        transfer in progress (NOT tx_ready)
//   done        one-cycle pulse when the device acknowledges the byte
//   error       one-cycle pulse on timeout or missing acknowledge
//   fsm_state   current FSM state, for observation
//
// Handshake: a byte is taken on a rising clk28 edge where tx_valid and
// tx_ready are both 1. tx_valid is ignored while busy, and nothing is queued.
module ps2_tx #(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] fsm_state
);

    // 64-bit intermediate: CLK_FREQ * TIMEOUT_US overflows 32 bits at the defaults.
    localparam int INH_CYC = int'((64'(CLK_FREQ) * 64'(INHIBIT_US)) / 64'd1000000);
    localparam int TO_CYC  = int'((64'(CLK_FREQ) * 64'(TIMEOUT_US)) / 64'd1000000);
    localparam int INH_W   = $clog2(INH_CYC + 1);
    localparam int TO_W    = ($clog2(TO_CYC + 1) > 19) ? $clog2(TO_CYC + 1) : 19;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]       state;
    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic             clk_fall;
    logic [INH_W-1:0] inh_cnt;
    logic             inh_last;
    logic [TO_W-1:0]  to_cnt;
    logic             to_active;
    logic             to_hit;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;      // {parity, d7..d0}; shifted out LSB first
    logic             dat_drive;  // inverted value of the bit currently presented

    // Two-flop synchronizers. They reset to 1 because the idle line level is high.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    assign clk_fall  = clk_prev & ~clk_sync[1];
    assign inh_last  = (inh_cnt == INH_W'(INH_CYC - 1));
    assign to_active = (state == S_RTS) || (state == S_DATA) ||
                       (state == S_ACK) || (state == S_RELEASE);
    // The hit is seen in cycle TO_CYC-1 after RTS entry.
    // The registered error pulse therefore lands TO_CYC cycles after entry.
    assign to_hit    = to_active && (to_cnt >= TO_W'(TO_CYC - 1));

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dat_drive <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            // The timeout counter saturates while active.
            // It is held at zero otherwise, so it always starts cleared on RTS entry.
            if (to_active) begin
                if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (to_hit) begin
                // Timeout takes priority over any clock edge in the same cycle.
                state     <= S_IDLE;
                dat_drive <= 1'b0;
                error     <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_valid) begin
                            shreg   <= {~^tx_data, tx_data};
                            inh_cnt <= '0;
                            state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (inh_last) begin
                            state <= S_RTS;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    S_RTS: begin
                        if (clk_fall) begin
                            dat_drive <= ~shreg[0];
                            shreg     <= {1'b0, shreg[8:1]};
                            bit_idx   <= 4'd1;
                            state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (clk_fall) begin
                            if (bit_idx == 4'd9) begin
                                // Tenth edge: release data for the stop bit.
                                dat_drive <= 1'b0;
                                state     <= S_ACK;
                            end else begin
                                dat_drive <= ~shreg[0];
                                shreg     <= {1'b0, shreg[8:1]};
                                bit_idx   <= bit_idx + 1'b1;
                            end
                        end
                    end
                    S_ACK: begin
                        if (clk_fall) begin
                            if (!dat_sync[1]) begin
                                state <= S_RELEASE;
                            end else begin
                                error <= 1'b1;
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (clk_sync[1] && dat_sync[1]) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Line drives are decoded from the state.
    // An asynchronous reset therefore releases both lines immediately.
    assign ps2_clk_oe = (state == S_INHIBIT);
    assign ps2_dat_oe = ((state == S_INHIBIT) && inh_last) ||
                        (state == S_RTS) ||
                        ((state == S_DATA) && dat_drive);
    assign tx_ready   = (state == S_IDLE);
    assign busy       = ~tx_ready;
    assign fsm_state  = state;

endmodule

// File: tb/tb_ps2_tx.sv
module tb_ps2_tx;
  localparam int CF   = 1_000_000;
  localparam int IU   = 100;
  localparam int TU   = 3000;
  localparam int INH  = CF / 1000 * IU / 1000;   // 100 cycles
  localparam int TO   = CF / 1000 * TU / 1000;   // 3000 cycles
  localparam int HALF = 20;                      // device clock half period (cycles)

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_dat_line;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // open-drain bus: either side pulling low wins
  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_tx #(.CLK_FREQ(CF), .INHIBIT_US(IU), .TIMEOUT_US(TU)) dut (
    .clk28(clk), .rst_n(rst_n),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_len = 0, dat_in_inh = 0, inh_starts = 0;
  logic last_dat = 1'b0, prev_clk_oe = 1'b0;
  int rts_cyc = 0, err_cyc = 0;
  int dev_falls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_clk_oe <= ps2_clk_oe;
    if (ps2_clk_oe && !prev_clk_oe) begin
      inh_starts <= inh_starts + 1;
      inh_len    <= 1;
      dat_in_inh <= ps2_dat_oe ? 1 : 0;
      last_dat   <= ps2_dat_oe;
    end else if (ps2_clk_oe) begin
      inh_len    <= inh_len + 1;
      dat_in_inh <= dat_in_inh + (ps2_dat_oe ? 1 : 0);
      last_dat   <= ps2_dat_oe;
    end
    if (!ps2_clk_oe && prev_clk_oe) rts_cyc <= cyc;
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done && error) both_cnt <= both_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, then clock n_clk bits.
  // Data is sampled just before each rising edge. On the 11th clock the device
  // pulls data low if ack is set.
  task automatic dev_xfer(input int n_clk, input bit ack, output logic [9:0] got, output bit ok);
    int t;
    got = '0;
    ok  = 1'b0;
    t   = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) return;
    ok = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < n_clk; i++) begin
      dev_clk_low = 1'b1;
      dev_falls++;
      repeat (HALF) @(negedge clk);
      if (i < 10) got[i] = ps2_dat_line;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == 9) dev_dat_low = ack;
    end
    dev_dat_low = 1'b0;
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [9:0] exp_q[$];

  // Frame seen on the line: d0..d7, odd parity, stop (1).
  task automatic model_frame(input logic [7:0] b);
    int ones;
    exp_q.delete();
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(10'((b >> i) & 1));
      ones += (b >> i) & 1;
    end
    exp_q.push_back((ones % 2 == 0) ? 10'd1 : 10'd0);
    exp_q.push_back(10'd1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
    checks++; if ({tx_ready, busy, done, error} !== 4'b1000) begin errors++;
      $display("FAIL reset_status: got %b want 1000 (ready busy done error)", {tx_ready, busy, done, error}); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_byte(input logic [7:0] b, input bit check_inhibit);
    logic [9:0] got, e;
    bit ok;
    int d0, e0, t;
    d0 = done_cnt;
    e0 = err_cnt;
    model_frame(b);
    start_tx(b);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_%02h: got %b want 1", b, busy); end
    dev_xfer(11, 1'b1, got, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rts_%02h: got no RTS want RTS", b); end
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++; if (got[i] !== e[0]) begin errors++; $display("FAIL bit%0d_%02h: got %b want %b", i, b, got[i], e[0]); end
    end
    t = 0;
    while (done_cnt == d0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_%02h: got %0d pulses want 1", b, done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL err_%02h: got %0d pulses want 0", b, err_cnt - e0); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_%02h: got %b want 1", b, tx_ready); end
    if (check_inhibit) begin
      checks++; if (inh_len !== INH) begin errors++; $display("FAIL inhibit_len: got %0d want %0d", inh_len, INH); end
      checks++; if (dat_in_inh !== 1) begin errors++; $display("FAIL inhibit_dat_cycles: got %0d want 1", dat_in_inh); end
      checks++; if (last_dat !== 1'b1) begin errors++; $display("FAIL inhibit_last_dat: got %b want 1", last_dat); end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) test_byte(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic test_timeout;
    int e0, d0, t;
    e0 = err_cnt;
    d0 = done_cnt;
    start_tx(8'hFF);
    t = 0;
    while (err_cnt == e0 && t < INH + TO + 500) begin @(negedge clk); t++; end
    @(negedge clk);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
    checks++; if (err_cyc - rts_cyc !== TO) begin errors++; $display("FAIL timeout_time: got %0d cycles want %0d", err_cyc - rts_cyc, TO); end
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL timeout_lines: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", tx_ready); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_nack;
    logic [9:0] got;
    bit ok;
    int e0, d0, t;
    e0 = err_cnt;
    d0 = done_cnt;
    start_tx(8'h00);
    dev_xfer(11, 1'b0, got, ok);
    checks++; if (got[7:0] !== 8'h00) begin errors++; $display("FAIL nack_data: got %02h want 00", got[7:0]); end
    checks++; if (got[8] !== 1'b1) begin errors++; $display("FAIL nack_parity: got %b want 1", got[8]); end
    t = 0;
    while (err_cnt == e0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL nack_err: got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_ignore_busy;
    logic [9:0] got, e;
    bit ok;
    int d0, s0, f0, t;
    d0 = done_cnt;
    s0 = inh_starts;
    model_frame(8'hF4);
    start_tx(8'hF4);
    f0 = dev_falls;
    fork
      dev_xfer(11, 1'b1, got, ok);
      begin
        t = 0;
        while (dev_falls < f0 + 3 && t < 2000) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      checks++; if (got[i] !== e[0]) begin errors++; $display("FAIL busy_req_bit%0d: got %b want %b", i, got[i], e[0]); end
    end
    repeat (300) @(negedge clk);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_req_done: got %0d want 1", done_cnt - d0); end
    checks++; if (inh_starts - s0 !== 1) begin errors++; $display("FAIL busy_req_queued: got %0d transfers want 1", inh_starts - s0); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] got;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    // 0xA5: d4 = 0, so the host is pulling data low after the 5th edge.
    start_tx(8'hA5);
    dev_xfer(5, 1'b0, got, ok);
    checks++; if (ps2_dat_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_dat: got %b want 1", ps2_dat_oe); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL mid_reset_lines: got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", tx_ready); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_reset_done: got %0d want 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL mid_reset_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] got, e;
    logic [7:0] cur;
    bit ok;
    int t;
    @(negedge clk);
    tx_data  = 8'($urandom_range(0, 255));
    tx_valid = 1'b1;
    @(negedge clk);
    cur     = tx_data;
    tx_data = 8'($urandom_range(0, 255));
    for (int k = 0; k < 3; k++) begin
      model_frame(cur);
      dev_xfer(11, 1'b1, got, ok);
      for (int i = 0; i < 10; i++) begin
        e = exp_q.pop_front();
        checks++; if (got[i] !== e[0]) begin errors++; $display("FAIL b2b%0d_bit%0d: got %b want %b", k, i, got[i], e[0]); end
      end
      t = 0;
      while (done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b%0d_done: got %b want 1", k, done); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready_at_done: got %b want 1", k, tx_ready); end
      if (k == 2) tx_valid = 1'b0;
      @(negedge clk);
      if (k < 2) begin
        checks++; if ({tx_ready, ps2_clk_oe} !== 2'b01) begin errors++;
          $display("FAIL b2b%0d_restart: got ready,clk_oe=%b want 01", k, {tx_ready, ps2_clk_oe}); end
        cur     = tx_data;
        tx_data = 8'($urandom_range(0, 255));
      end else begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_stop_ready: got %b want 1", tx_ready); end
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_exclusive;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_error_overlap: got %0d cycles want 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_byte(8'hED, 1'b1);
    test_random;
    test_timeout;
    test_nack;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    test_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
